dvi_rx_monitor: RTL and testbench
=================================

Name: dvi_rx_monitor

Overview:
- Receive-side counterpart of the 12-bit DDR DVI transmitter interface (V1_D, HSYNC, VSYNC, DE).
- Reassembles 24-bit pixels from the two 12-bit half-words.
- Measures horizontal and vertical timing, declares lock after consistent frames, and computes a per-frame checksum of active pixels.
- Used on-chip for loopback self-test and as the synthesizable capture model in video benches.

Parameters:
- LOCK_FRAMES, 2: consecutive identical frame measurements required to assert locked.
- CNT_W, 12: width of all horizontal/vertical counters and measurement outputs.

Ports:
- clk  in  1  pixel clock (same frequency as XCLK); all logic on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- d_rise  in  12  half-word captured on XCLK rising edge: {G[3:0],B[7:0]}.
- d_fall  in  12  half-word captured on XCLK falling edge: {R[7:0],G[7:4]}.
- hsync  in  1  horizontal sync, active-high (polarity fixed).
- vsync  in  1  vertical sync, active-high.
- de  in  1  data enable.
- pix_valid  out  1  registered copy of de.
- pix_rgb  out  24  {R,G,B}.
- pix_x  out  CNT_W  column of pix_rgb within the active line.
- pix_y  out  CNT_W  active line index of pix_rgb.
- frame_start  out  1  one-cycle pulse with the first active pixel of a frame.
- h_total, h_active, h_sync_w  out  CNT_W each  last complete line measurement.
- v_total, v_active, v_sync_w  out  CNT_W each  last complete frame measurement, in lines.
- frame_sum  out  32  modulo-2^32 sum of all 24-bit active pixels of the last complete frame.
- sum_valid  out  1  one-cycle pulse when frame_sum updates.
- locked  out  1  timing stable.

Behaviour:
- Reset (async assert, sync deassert not required inside the block): every output and internal counter resets to 0; the FSM goes to IDLE.
- Pixel path latency is 1 cycle. pix_rgb = {d_fall[11:4], d_fall[3:0], d_rise[11:8], d_rise[7:0]}.
- pix_x resets to 0 on the first de cycle of a line and increments on each subsequent de cycle.
- pix_y increments on the first de cycle of each line after the first line of the frame.
- Edge detection uses 1-cycle registered copies of hsync, vsync and de.
- Line boundary is the hsync rising edge.
  - h_total = cycles between consecutive hsync rises.
  - h_sync_w = hsync high cycles.
  - h_active = de-high cycles in that line.
  - All three latch at the hsync rise.
- Frame boundary is the vsync rising edge.
  - v_total = hsync rises between consecutive vsync rises.
  - v_sync_w = hsync rises while vsync is high.
  - v_active = lines containing at least one de cycle.
  - At the frame boundary frame_sum latches, sum_valid pulses and the accumulator clears.
- frame_start fires with pix_valid on the first de cycle after a vsync rise.
- Counters saturate at all-ones (2^CNT_W-1) and do not wrap; a saturated value never compares as matching.
- FSM states:
  - IDLE: waits for the first vsync rise, then goes to MEASURE.
  - MEASURE: at each vsync rise, compares the 6-field frame measurement with the previous frame's.
    - On a match, match_cnt increments; on a mismatch, match_cnt clears to 0.
    - When match_cnt reaches LOCK_FRAMES-1, the FSM goes to LOCKED.
  - LOCKED: locked = 1.
    - Any line whose h_total or h_active differs from the locked value, or any frame mismatch, causes transition to MEASURE with match_cnt = 0.
    - locked drops in the cycle after the detecting edge.
- If hsync and vsync rise in the same cycle, the line boundary is processed first and the frame measurement includes that line.
- de asserted during hsync or vsync is counted normally; no error flag.
- Reset mid-frame discards partial measurements. The first frame after reset never produces sum_valid (no preceding vsync).

Test Plan:
- 640x480 timing, 800x525 totals, hsync 96, vsync 2, constant pixel 0x123456 → after 3 vsync rises: locked = 1, h_total = 800, h_active = 640, h_sync_w = 96, v_total = 525, v_active = 480, v_sync_w = 2, frame_sum = 307200*0x123456 mod 2^32.
- d_rise = 0xABC, d_fall = 0xDEF with de = 1 → pix_rgb = 0xDEFABC one cycle later; pix_x counts 0..639; frame_start coincides with pix_x = 0, pix_y = 0.
- Locked, then one line shortened to h_total = 799 → locked = 0 from the next cycle; relock requires LOCK_FRAMES clean frames.
- hsync and vsync rising on the same cycle → v_total counts that line; no spurious mismatch; lock retained.
- reset_n pulsed low for 1 cycle mid-frame → all outputs 0 immediately; no sum_valid until the second vsync rise after release.
- hsync held low for more than 4096 cycles → h_total = 0xFFF (saturated); locked never asserts.

Source files
------------

// File: rtl/dvi_rx_monitor.sv
// dvi_rx_monitor: receive-side monitor for a 12-bit DDR DVI link.
// Rebuilds 24-bit pixels from rise/fall half-words, measures line and frame
// timing, sums active pixels per frame and declares lock once the timing is stable.
// Ports:
//   clk, reset_n                      pixel clock, async active-low reset
//   d_rise {G[3:0],B}, d_fall {R,G[7:4]}, hsync, vsync, de   link inputs
//   pix_valid, pix_rgb, pix_x, pix_y, frame_start            1-cycle pixel stream
//   h_total, h_active, h_sync_w                              last line measurement
//   v_total, v_active, v_sync_w                              last frame measurement
//   frame_sum, sum_valid                                     per-frame pixel sum
//   locked                                                   timing stable
module dvi_rx_monitor #(
    parameter int LOCK_FRAMES = 2,
    parameter int CNT_W       = 12
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [11:0]      d_rise,
    input  logic [11:0]      d_fall,
    input  logic             hsync,
    input  logic             vsync,
    input  logic             de,
    output logic             pix_valid,
    output logic [23:0]      pix_rgb,
    output logic [CNT_W-1:0] pix_x,
    output logic [CNT_W-1:0] pix_y,
    output logic             frame_start,
    output logic [CNT_W-1:0] h_total,
    output logic [CNT_W-1:0] h_active,
    output logic [CNT_W-1:0] h_sync_w,
    output logic [CNT_W-1:0] v_total,
    output logic [CNT_W-1:0] v_active,
    output logic [CNT_W-1:0] v_sync_w,
    output logic [31:0]      frame_sum,
    output logic             sum_valid,
    output logic             locked
);
    localparam logic [CNT_W-1:0] MAX = '1;
    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam int MW = $clog2(LOCK_FRAMES + 1);
    localparam logic [MW-1:0] LOCK_TGT = MW'(LOCK_FRAMES - 1);

    typedef enum logic [1:0] {IDLE, MEASURE, LOCKED} state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic             r_hs, r_vs, r_de, r_first, r_line_de;
    logic [CNT_W-1:0] r_hcnt, r_hact, r_hsw, r_vcnt, r_vact, r_vsw;
    logic [31:0]      r_acc;
    logic [CNT_W-1:0] r_p_htot, r_p_hact, r_p_hsw, r_p_vtot, r_p_vact, r_p_vsw;
    logic             r_p_ok, r_dirty;
    state_t           r_state;
    logic [MW-1:0]    r_match_cnt;

    logic             w_hs_rise, w_vs_rise, w_de_rise, w_first;
    logic [23:0]      w_pix;
    logic [CNT_W-1:0] w_f_htot, w_f_hact, w_f_hsw, w_f_vtot, w_f_vact, w_f_vsw;
    logic             w_sat, w_same, w_line_bad, w_dirty, w_match;
    logic [MW-1:0]    w_cnt_inc;

    assign w_hs_rise = hsync & ~r_hs;
    assign w_vs_rise = vsync & ~r_vs;
    assign w_de_rise = de & ~r_de;
    assign w_first   = r_first | w_vs_rise;
    assign w_pix     = {d_fall, d_rise};

    // Frame measurement as it stands at this edge: a line ending on the same
    // cycle as the vsync rise belongs to the frame that is closing. h_active
    // tracks the last line that carried de so blanking lines do not zero it.
    assign w_f_htot = w_hs_rise ? r_hcnt : h_total;
    assign w_f_hact = (w_hs_rise & r_line_de) ? r_hact : h_active;
    assign w_f_hsw  = w_hs_rise ? r_hsw : h_sync_w;
    assign w_f_vtot = w_hs_rise ? sat_inc(r_vcnt) : r_vcnt;
    assign w_f_vact = (w_hs_rise & r_line_de) ? sat_inc(r_vact) : r_vact;
    assign w_f_vsw  = r_vsw;

    assign w_sat = (w_f_htot == MAX) | (w_f_hact == MAX) | (w_f_hsw == MAX) |
                   (w_f_vtot == MAX) | (w_f_vact == MAX) | (w_f_vsw == MAX);
    assign w_same = (w_f_htot == r_p_htot) & (w_f_hact == r_p_hact) & (w_f_hsw == r_p_hsw) &
                    (w_f_vtot == r_p_vtot) & (w_f_vact == r_p_vact) & (w_f_vsw == r_p_vsw);

    // Per-line check while locked; h_active only matters on lines carrying de.
    assign w_line_bad = w_hs_rise & ((r_hcnt != r_p_htot) | (r_hcnt == MAX) |
                        (r_line_de & ((r_hact != r_p_hact) | (r_hact == MAX))));
    // A frame that saw a bad line can neither match nor serve as a reference.
    assign w_dirty   = r_dirty | ((r_state == LOCKED) & w_line_bad);
    assign w_match   = w_same & ~w_sat & r_p_ok & ~w_dirty;
    assign w_cnt_inc = r_match_cnt + 1'b1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hs        <= 1'b0;
            r_vs        <= 1'b0;
            r_de        <= 1'b0;
            r_first     <= 1'b0;
            r_line_de   <= 1'b0;
            r_hcnt      <= '0;
            r_hact      <= '0;
            r_hsw       <= '0;
            r_vcnt      <= '0;
            r_vact      <= '0;
            r_vsw       <= '0;
            r_acc       <= '0;
            pix_valid   <= 1'b0;
            pix_rgb     <= '0;
            pix_x       <= '0;
            pix_y       <= '0;
            frame_start <= 1'b0;
            h_total     <= '0;
            h_active    <= '0;
            h_sync_w    <= '0;
            v_total     <= '0;
            v_active    <= '0;
            v_sync_w    <= '0;
            frame_sum   <= '0;
            sum_valid   <= 1'b0;
        end else begin
            r_hs        <= hsync;
            r_vs        <= vsync;
            r_de        <= de;
            pix_valid   <= de;
            pix_rgb     <= w_pix;
            frame_start <= w_de_rise & w_first;
            r_first     <= w_de_rise ? 1'b0 : w_first;
            if (w_de_rise) begin
                pix_x <= '0;
                pix_y <= w_first ? '0 : sat_inc(pix_y);
            end else if (de) begin
                pix_x <= sat_inc(pix_x);
            end
            if (w_hs_rise) begin
                h_total   <= r_hcnt;
                h_sync_w  <= r_hsw;
                h_active  <= w_f_hact;
                r_hcnt    <= ONE;
                r_hsw     <= ONE;
                r_hact    <= de ? ONE : '0;
                r_line_de <= de;
                r_vcnt    <= w_f_vtot;
                r_vact    <= w_f_vact;
                r_vsw     <= vsync ? sat_inc(r_vsw) : r_vsw;
            end else begin
                r_hcnt    <= sat_inc(r_hcnt);
                r_hsw     <= hsync ? sat_inc(r_hsw) : r_hsw;
                r_hact    <= de ? sat_inc(r_hact) : r_hact;
                r_line_de <= r_line_de | de;
            end
            // The hsync rise coinciding with a vsync rise opens the new
            // frame's sync pulse, so it seeds the new v_sync_w count.
            if (w_vs_rise) begin
                v_total   <= w_f_vtot;
                v_active  <= w_f_vact;
                v_sync_w  <= w_f_vsw;
                r_vcnt    <= '0;
                r_vact    <= '0;
                r_vsw     <= w_hs_rise ? ONE : '0;
                sum_valid <= (r_state != IDLE);
                frame_sum <= (r_state != IDLE) ? r_acc : frame_sum;
                r_acc     <= de ? 32'(w_pix) : '0;
            end else begin
                sum_valid <= 1'b0;
                r_acc     <= de ? r_acc + 32'(w_pix) : r_acc;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_match_cnt <= '0;
            locked      <= 1'b0;
            r_dirty     <= 1'b0;
            r_p_ok      <= 1'b0;
            r_p_htot    <= '0;
            r_p_hact    <= '0;
            r_p_hsw     <= '0;
            r_p_vtot    <= '0;
            r_p_vact    <= '0;
            r_p_vsw     <= '0;
        end else begin
            r_dirty <= w_vs_rise ? 1'b0 : w_dirty;
            if (w_vs_rise) begin
                r_p_htot <= w_f_htot;
                r_p_hact <= w_f_hact;
                r_p_hsw  <= w_f_hsw;
                r_p_vtot <= w_f_vtot;
                r_p_vact <= w_f_vact;
                r_p_vsw  <= w_f_vsw;
                r_p_ok   <= ~w_dirty;
            end
            case (r_state)
                IDLE: begin
                    if (w_vs_rise) r_state <= MEASURE;
                end
                MEASURE: begin
                    if (w_vs_rise & w_match) begin
                        r_match_cnt <= w_cnt_inc;
                        if (w_cnt_inc >= LOCK_TGT) begin
                            r_state <= LOCKED;
                            locked  <= 1'b1;
                        end
                    end else if (w_vs_rise) begin
                        r_match_cnt <= '0;
                    end
                end
                LOCKED: begin
                    if (w_line_bad | (w_vs_rise & ~w_match)) begin
                        r_state     <= MEASURE;
                        r_match_cnt <= '0;
                        locked      <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    locked  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dvi_rx_monitor.sv
// tb_dvi_rx_monitor: directed frame sequences with random pixel data, checked
// against a frame-level model of the monitor's measurements, sums and lock rule.
module tb_dvi_rx_monitor;
    localparam int LF = 2;
    localparam int HT = 40, HA = 24, HS = 6, HB = 12;
    localparam int VT = 20, VA = 12, VS = 2, VB = 4;

    logic        clk, reset_n, hsync, vsync, de;
    logic [11:0] d_rise, d_fall;
    logic        pix_valid, frame_start, sum_valid, locked;
    logic [23:0] pix_rgb;
    logic [11:0] pix_x, pix_y, h_total, h_active, h_sync_w, v_total, v_active, v_sync_w;
    logic [31:0] frame_sum;
    logic        any_out;

    dvi_rx_monitor #(.LOCK_FRAMES(LF), .CNT_W(12)) dut (
        .clk(clk), .reset_n(reset_n), .d_rise(d_rise), .d_fall(d_fall),
        .hsync(hsync), .vsync(vsync), .de(de),
        .pix_valid(pix_valid), .pix_rgb(pix_rgb), .pix_x(pix_x), .pix_y(pix_y),
        .frame_start(frame_start), .h_total(h_total), .h_active(h_active),
        .h_sync_w(h_sync_w), .v_total(v_total), .v_active(v_active),
        .v_sync_w(v_sync_w), .frame_sum(frame_sum), .sum_valid(sum_valid),
        .locked(locked)
    );

    assign any_out = |{pix_valid, pix_rgb, pix_x, pix_y, frame_start, h_total, h_active,
                       h_sync_w, v_total, v_active, v_sync_w, frame_sum, sum_valid, locked};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    int checks = 0, passed = 0;
    // Model state: rises since reset, whether the current frame began at a
    // vsync rise after reset, run of clean complete frames, expected lock.
    int          rises, run;
    bit          full, glitch_frame, exp_lock, seen_lock;
    logic [31:0] acc;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic cyc(input bit hs, input bit vs, input bit dv, input logic [23:0] p);
        hsync  = hs;
        vsync  = vs;
        de     = dv;
        d_fall = p[23:12];
        d_rise = p[11:0];
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        rises = 0;
        run = 0;
        full = 0;
        glitch_frame = 0;
        exp_lock = 0;
        acc = '0;
    endtask

    task automatic rst_pulse();
        reset_n = 1'b0;
        #1;
        chk("reset_zero", any_out, 0);
        @(posedge clk);
        #1;
        chk("reset_hold_zero", any_out, 0);
        reset_n = 1'b1;
        model_reset();
    endtask

    task automatic at_rise();
        chk("sum_valid", sum_valid, rises >= 1);
        if (rises >= 1) chk("frame_sum", frame_sum, acc);
        run = (full && !glitch_frame) ? run + 1 : 0;
        exp_lock = run >= LF;
        chk("locked_rise", locked, exp_lock);
        if (full) begin
            chk("h_total", h_total, HT);
            chk("h_active", h_active, HA);
            chk("h_sync_w", h_sync_w, HS);
            chk("v_total", v_total, VT);
            chk("v_active", v_active, VA);
            chk("v_sync_w", v_sync_w, VS);
        end
        rises++;
        full = 1;
        glitch_frame = 0;
        acc = '0;
    endtask

    task automatic frame(input int short_line, input int rst_line);
        for (int l = 0; l < VT; l++) begin
            int len;
            len = (l == short_line) ? HT - 1 : HT;
            for (int c = 0; c < len; c++) begin
                bit act;
                logic [23:0] p;
                act = l >= VB && l < VB + VA && c >= HB && c < HB + HA;
                p = 24'($urandom);
                cyc(c < HS, l < VS, act, p);
                if (act) acc += {8'h0, p};
                if (c == 0 && l == 0) at_rise();
                else if (c == 0) begin
                    if (l == short_line + 1) begin
                        exp_lock = 0;
                        glitch_frame = 1;
                    end
                    chk("locked_line", locked, exp_lock);
                    if (full) chk("h_total_line", h_total, (l == short_line + 1) ? HT - 1 : HT);
                end
                if (c == 1 && l == 0) chk("sum_valid_pulse", sum_valid, 0);
                if (act && full)
                    chk("pix", {pix_valid, pix_rgb, pix_x, pix_y, frame_start},
                        {1'b1, p, 12'(c - HB), 12'(l - VB), l == VB && c == HB});
                if (c == 0 && l == rst_line) rst_pulse();
            end
        end
    endtask

    initial begin
        reset_n = 1'b0;
        hsync = 0;
        vsync = 0;
        de = 0;
        d_rise = '0;
        d_fall = '0;
        model_reset();
        @(posedge clk);
        #1;
        chk("por_zero", any_out, 0);
        reset_n = 1'b1;
        cyc(0, 0, 1, 24'hDEFABC);
        chk("pix_direct", {pix_valid, pix_rgb}, {1'b1, 24'hDEFABC});
        cyc(0, 0, 0, 24'h0);
        chk("pix_valid_low", pix_valid, 0);
        repeat (4) frame(-1, -1);
        frame(8, -1);
        repeat (3) frame(-1, -1);
        frame(-1, 10);
        repeat (4) frame(-1, -1);
        rst_pulse();
        seen_lock = 0;
        for (int it = 0; it < 4; it++) begin
            cyc(1, 1, 0, 24'($urandom));
            chk("sat_locked", locked, 0);
            chk("sat_sum_valid", sum_valid, it >= 1);
            if (it >= 1) begin
                chk("sat_h_total", h_total, 12'hFFF);
                chk("sat_v_total", v_total, 1);
                chk("sat_frame_sum", frame_sum, 0);
            end
            cyc(1, 1, 0, 24'($urandom));
            for (int k = 0; k < 5000; k++) begin
                cyc(0, 0, 0, 24'($urandom));
                seen_lock |= locked;
            end
        end
        chk("sat_never_locked", seen_lock, 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
